// File: rtl/crtc_pkg.sv
// crtc_pkg: register indices, blink modes and vertical phase shared by the CRTC slice
package crtc_pkg;
    localparam logic [3:0] R_HTOTAL = 4'd0;
    localparam logic [3:0] R_HDISP  = 4'd1;
    localparam logic [3:0] R_HSPOS  = 4'd2;
    localparam logic [3:0] R_SYNCW  = 4'd3;
    localparam logic [3:0] R_VTOTAL = 4'd4;
    localparam logic [3:0] R_VADJ   = 4'd5;
    localparam logic [3:0] R_VDISP  = 4'd6;
    localparam logic [3:0] R_VSPOS  = 4'd7;
    localparam logic [3:0] R_MAXSL  = 4'd9;
    localparam logic [3:0] R_CURST  = 4'd10;
    localparam logic [3:0] R_CUREND = 4'd11;
    localparam logic [3:0] R_STARTH = 4'd12;
    localparam logic [3:0] R_STARTL = 4'd13;
    localparam logic [3:0] R_CURH   = 4'd14;
    localparam logic [3:0] R_CURL   = 4'd15;

    typedef enum logic [1:0] {
        BLINK_ON  = 2'b00,
        BLINK_OFF = 2'b01,
        BLINK_16  = 2'b10,
        BLINK_32  = 2'b11
    } blink_e;

    typedef enum logic {V_ROWS, V_ADJ} vstate_e;

    // ph holds frame counter bits [5:4]; the cursor shows while the selected bit is low
    function automatic logic blink_phase(input blink_e mode, input logic [1:0] ph);
        return mode == BLINK_ON ? 1'b1 : mode == BLINK_OFF ? 1'b0 : mode == BLINK_16 ? ~ph[0] : ~ph[1];
    endfunction
endpackage

// File: rtl/crtc_regfile.sv
// crtc_regfile: address register, R0-R15 and bus decode; only R14/R15 read back
module crtc_regfile
    import crtc_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CSn,
    input  logic             RS,
    input  logic             WEn,
    input  logic [7:0]       DIN,
    output logic [7:0]       DOUT,
    output logic [15:0][7:0] regs,
    output logic             r3_set
);
    logic [4:0] ar;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ar     <= '0;
            regs   <= '0;
            r3_set <= 1'b0;
        end else if (!CSn && !WEn) begin
            if (!RS)
                ar <= DIN[4:0];
            else if (!ar[4]) begin
                regs[ar[3:0]] <= DIN;
                if (ar[3:0] == R_SYNCW)
                    r3_set <= 1'b1;
            end
        end
    end

    assign DOUT = ar == {1'b0, R_CURH} ? regs[R_CURH] :
                  ar == {1'b0, R_CURL} ? regs[R_CURL] : 8'h00;
endmodule

// File: rtl/crtc_timing_gen.sv
// crtc_timing_gen: 6845-style CRT controller producing sync, display enable,
// refresh address, raster address and cursor from the programmed registers.
module crtc_timing_gen
    import crtc_pkg::*;
#(
    parameter int HW  = 8,
    parameter int VW  = 7,
    parameter int SW  = 5,
    parameter int MAW = 14
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic           CSn,
    input  logic           RS,
    input  logic           WEn,
    input  logic [7:0]     DIN,
    output logic [7:0]     DOUT,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           DE,
    output logic           CURSOR,
    output logic [MAW-1:0] MA,
    output logic [SW-1:0]  RA
);
    logic [15:0][7:0] regs;
    logic             r3_set;
    logic             unused_regs;

    crtc_regfile u_regs (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .CSn    (CSn),
        .RS     (RS),
        .WEn    (WEn),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .regs   (regs),
        .r3_set (r3_set)
    );

    assign unused_regs = ^regs;

    logic [HW-1:0]  hcnt, hcnt_n;
    logic [SW-1:0]  ra, ra_n;
    logic [VW-1:0]  row, row_n;
    vstate_e        vst, vst_n;
    logic [MAW-1:0] lstart, lstart_n;
    logic [5:0]     fc, fc_n;
    logic [3:0]     hs_rem, hs_rem_n, hs_w;
    logic [4:0]     vs_rem, vs_rem_n, vs_w;
    logic           h_end, line_end, adj_end, frame_end, hs_start, vs_start;

    assign hs_w = regs[R_SYNCW][3:0];
    assign vs_w = regs[R_SYNCW][7:4] == 4'd0 ? 5'd16 : {1'b0, regs[R_SYNCW][7:4]};

    always_comb begin
        h_end     = hcnt == HW'(regs[R_HTOTAL]);
        line_end  = ra == SW'(regs[R_MAXSL]);
        adj_end   = ra + 1'b1 == SW'(regs[R_VADJ]);
        frame_end = h_end && (vst == V_ADJ ? adj_end :
                    line_end && row == VW'(regs[R_VTOTAL]) && SW'(regs[R_VADJ]) == '0);
        hs_start  = hs_w != 4'd0 && hcnt == HW'(regs[R_HSPOS]);
        // VSYNC stays off after reset until the sync-width register has been programmed
        vs_start  = r3_set && vst == V_ROWS && hcnt == '0 && ra == '0 && row == VW'(regs[R_VSPOS]);
        hcnt_n    = h_end ? '0 : hcnt + 1'b1;
        ra_n      = ra;
        row_n     = row;
        vst_n     = vst;
        lstart_n  = lstart;
        fc_n      = fc;
        if (frame_end) begin
            ra_n     = '0;
            row_n    = '0;
            vst_n    = V_ROWS;
            lstart_n = MAW'({regs[R_STARTH], regs[R_STARTL]});
            fc_n     = fc + 1'b1;
        end else if (h_end) begin
            if (vst == V_ADJ || !line_end)
                ra_n = ra + 1'b1;
            else begin
                ra_n     = '0;
                lstart_n = lstart + MAW'(regs[R_HDISP]);
                if (row == VW'(regs[R_VTOTAL]))
                    vst_n = V_ADJ;
                else
                    row_n = row + 1'b1;
            end
        end
        hs_rem_n = hs_start ? hs_w - 4'd1 : hs_rem != 4'd0 ? hs_rem - 4'd1 : 4'd0;
        vs_rem_n = vs_start ? vs_w - {4'd0, h_end} :
                   (h_end && vs_rem != 5'd0) ? vs_rem - 5'd1 : vs_rem;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hcnt   <= '0;
            ra     <= '0;
            row    <= '0;
            vst    <= V_ROWS;
            lstart <= '0;
            fc     <= '0;
            hs_rem <= '0;
            vs_rem <= '0;
        end else begin
            hcnt   <= hcnt_n;
            ra     <= ra_n;
            row    <= row_n;
            vst    <= vst_n;
            lstart <= lstart_n;
            fc     <= fc_n;
            hs_rem <= hs_rem_n;
            vs_rem <= vs_rem_n;
        end
    end

    assign HSYNC  = hs_start || hs_rem != 4'd0;
    assign VSYNC  = vs_start || vs_rem != 5'd0;
    assign DE     = hcnt < HW'(regs[R_HDISP]) && row < VW'(regs[R_VDISP]) && vst == V_ROWS;
    assign MA     = lstart + MAW'(hcnt);
    assign RA     = ra;
    assign CURSOR = DE && MA == MAW'({regs[R_CURH], regs[R_CURL]}) &&
                    ra >= SW'(regs[R_CURST][4:0]) && ra <= SW'(regs[R_CUREND]) &&
                    blink_phase(blink_e'(regs[R_CURST][6:5]), fc[5:4]);
endmodule

// File: tb/tb_crtc_timing_gen.sv
// tb_crtc_timing_gen: directed bench; per-cycle frame expectations go through a scoreboard queue
module tb_crtc_timing_gen;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        CSn = 1'b1;
    logic        RS = 1'b0;
    logic        WEn = 1'b1;
    logic [7:0]  DIN = 8'h00;
    logic [7:0]  DOUT;
    logic        HSYNC, VSYNC, DE, CURSOR;
    logic [13:0] MA;
    logic [4:0]  RA;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        cur;
        logic [13:0] ma;
        logic [4:0]  ra;
    } out_t;

    out_t got;
    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    crtc_timing_gen dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .CSn    (CSn),
        .RS     (RS),
        .WEn    (WEn),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .DE     (DE),
        .CURSOR (CURSOR),
        .MA     (MA),
        .RA     (RA)
    );

    assign got = {HSYNC, VSYNC, DE, CURSOR, MA, RA};

    task automatic check_out(input out_t e);
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL frame_cycle: got hs=%0b vs=%0b de=%0b cur=%0b ma=%h ra=%0d, expected hs=%0b vs=%0b de=%0b cur=%0b ma=%h ra=%0d",
                     got.hs, got.vs, got.de, got.cur, got.ma, got.ra, e.hs, e.vs, e.de, e.cur, e.ma, e.ra);
        end
    endtask

    always @(negedge CLK) if (sb.size() != 0) check_out(sb.pop_front());

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic rs, input logic [7:0] d);
        @(negedge CLK);
        CSn = 1'b0; RS = rs; WEn = 1'b0; DIN = d;
        @(negedge CLK);
        CSn = 1'b1; WEn = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] idx, input logic [7:0] val);
        bus(1'b0, idx);
        bus(1'b1, val);
    endtask

    // returns at the negedge where VSYNC is first seen low after being high
    task automatic sync_vs(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = VSYNC;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (prev && !VSYNC) begin
                ok = 1'b1;
                return;
            end
            prev = VSYNC;
        end
        chk("sync_timeout", 0, 1);
    endtask

    // 10-clock lines, 2 scanlines per row, rows 0-3, one adjust line: 90-clock frame
    function automatic out_t exp_at(input int t, input bit cur_on);
        out_t e;
        int line, h, row;
        line  = t / 10;
        h     = t % 10;
        row   = line / 2;
        e.hs  = (h == 7 || h == 8);
        e.vs  = (line == 6 || line == 7);
        e.de  = (line < 4 && h < 6);
        e.ma  = (line == 8) ? 14'('h118 + h) : 14'('h100 + row * 6 + h);
        e.ra  = (line == 8) ? 5'd0 : 5'(line % 2);
        e.cur = e.de && e.ma == 14'h103 && cur_on;
        return e;
    endfunction

    initial begin
        bit   ok;
        int   cnt, hs_cnt, run, cur_run, nruns, bad;
        logic prev;
        bit   seen_rise, found;
        int   cc[72];

        #12;
        chk("reset_outputs", int'({HSYNC, VSYNC, DE, CURSOR, MA, RA, DOUT}), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cnt += int'(DE) + int'(HSYNC) + int'(VSYNC) + int'(CURSOR);
        end
        chk("idle_quiet", cnt, 0);

        wr_reg(9, 8'd1);   wr_reg(4, 8'd3);   wr_reg(5, 8'd1);   wr_reg(6, 8'd2);
        wr_reg(7, 8'd3);   wr_reg(3, 8'h22);  wr_reg(2, 8'd7);   wr_reg(1, 8'd6);
        wr_reg(12, 8'h01); wr_reg(13, 8'h00); wr_reg(14, 8'h01); wr_reg(15, 8'h03);
        wr_reg(10, 8'h00); wr_reg(11, 8'd1);  wr_reg(0, 8'd9);
        repeat (200) @(negedge CLK);

        sync_vs(ok);
        if (ok) begin
            for (int k = 0; k < 180; k++) begin
                @(posedge CLK);
                sb.push_back(exp_at((81 + k) % 90, 1'b1));
            end
            repeat (2) @(negedge CLK);
        end
        chk("scoreboard_drained", sb.size(), 0);

        wr_reg(10, 8'h40);
        sync_vs(ok);
        for (int f = 0; f < 72; f++) begin
            cnt = 0; found = 1'b0; prev = VSYNC;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge CLK);
                cnt += int'(CURSOR);
                if (prev && !VSYNC) found = 1'b1;
                prev = VSYNC;
            end
            cc[f] = found ? cnt : -1;
        end
        bad = 0;
        for (int f = 0; f < 72; f++) if (cc[f] != 0 && cc[f] != 2) bad++;
        chk("blink_frame_counts", bad, 0);
        nruns = 0; run = 1;
        for (int f = 1; f < 72; f++) begin
            if (cc[f] == cc[f-1]) run++;
            else begin
                if (nruns > 0) chk("blink_run_len", run, 16);
                nruns++;
                run = 1;
            end
        end
        chk("blink_transitions", int'(nruns >= 3), 1);

        wr_reg(10, 8'h20);
        sync_vs(ok);
        cnt = 0;
        for (int i = 0; i < 270; i++) begin
            @(negedge CLK);
            cnt += int'(CURSOR);
        end
        chk("blink_off", cnt, 0);

        bus(1'b0, 8'd14);
        chk("dout_r14_initial", int'(DOUT), 8'h01);
        wr_reg(14, 8'h3F);
        chk("dout_r14", int'(DOUT), 8'h3F);
        bus(1'b0, 8'd15);
        chk("dout_r15", int'(DOUT), 8'h03);
        bus(1'b0, 8'd0);
        chk("dout_r0", int'(DOUT), 8'h00);
        bus(1'b0, 8'd30);
        bus(1'b1, 8'h55);
        chk("dout_ar30", int'(DOUT), 8'h00);
        bus(1'b0, 8'd20);
        bus(1'b1, 8'h55);
        bus(1'b0, 8'd14);
        chk("dout_r14_kept", int'(DOUT), 8'h3F);

        sync_vs(ok);
        cnt = 0; found = 1'b0; prev = VSYNC;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge CLK);
            cnt++;
            if (prev && !VSYNC) found = 1'b1;
            prev = VSYNC;
        end
        chk("frame_len", cnt, 90);

        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (HSYNC) found = 1'b1;
        end
        chk("hsync_seen", int'(found), 1);
        #1 RSTn = 1'b0;
        #1 chk("reset_async", int'({HSYNC, VSYNC, DE, CURSOR, MA, RA, DOUT}), 0);
        #2 RSTn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            cnt += int'(DE) + int'(HSYNC) + int'(VSYNC);
        end
        chk("post_reset_quiet", cnt, 0);

        wr_reg(9, 8'd1); wr_reg(4, 8'd9); wr_reg(7, 8'd2); wr_reg(3, 8'h00); wr_reg(0, 8'd9);
        repeat (300) @(negedge CLK);
        hs_cnt = 0; run = -1; cur_run = 0; seen_rise = 1'b0; prev = VSYNC;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            hs_cnt += int'(HSYNC);
            if (!prev && VSYNC) begin
                seen_rise = 1'b1;
                cur_run = 0;
            end
            if (VSYNC) cur_run++;
            if (prev && !VSYNC && seen_rise && run < 0) run = cur_run;
            prev = VSYNC;
        end
        chk("vsync_16_lines", run, 160);
        chk("no_hsync_width0", hs_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
